// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive halves:
//   tx_state_e : transmitter FSM states (IDLE/START/DATA/PARITY/STOP)
//   PAR_EVEN   : par_type value selecting even parity (bit = ^data)
//   PAR_ODD    : par_type value selecting odd parity  (bit = ~^data)
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : uart_pkg

// File: rtl/parity_bit_generator.sv
// ----------------------------------------------------------------------------
// parity_bit_generator
// Combinational parity for one data word; the transmitter registers the
// result when it accepts a byte.
// Ports:
//   data     in  DATA_WIDTH  word to protect
//   par_type in  1           PAR_EVEN (0) or PAR_ODD (1)
//   parity   out 1           parity bit to place on the line
// ----------------------------------------------------------------------------
module parity_bit_generator
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_type,
    output logic                  parity
);

    // Even parity is the XOR of all bits; odd parity inverts it.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic                  odd);
        return (^d) ^ odd;
    endfunction

    // Parity bit selected by the requested convention.
    always_comb begin
        parity = calc_parity(data, (par_type == PAR_ODD));
    end

endmodule : parity_bit_generator

// File: rtl/uart_transmitter.sv
// ----------------------------------------------------------------------------
// uart_transmitter
// Serialises one byte per transaction into an async UART frame:
// start (0), DATA_WIDTH data bits LSB first, optional parity, STOP_BITS
// stop bits (1). Bit timing comes from sample_tick, OVERSAMPLE ticks per bit.
//
// Build option: define UART_TX_PARITY_EN to insert the parity bit between
// the last data bit and the stop bit(s). Without it par_type has no effect
// on the line and the frame is one bit shorter.
//
// Ports:
//   clk          in   1           system clock, posedge
//   reset        in   1           synchronous, active-high
//   sample_tick  in   1           oversampling tick (one clk wide)
//   tx_valid     in   1           request to send tx_data
//   tx_data      in   DATA_WIDTH  byte, sampled on accept
//   par_type     in   1           0 even / 1 odd, sampled on accept
//   tx_ready     out  1           high only while idle
//   tx_serial    out  1           serial line, idles high
//   tx_done      out  1           one-clk pulse at end of last stop bit
// ----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  par_type,
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_done
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    // bit_cnt indexes data bits and, in STOP, counts stop bits.
    localparam int BIT_W  = $clog2(DATA_WIDTH + STOP_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e             state_r;
    logic [TICK_W-1:0]     tick_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  parity_r;
    logic                  tx_ready_r;
    logic                  tx_serial_r;
    logic                  tx_done_r;

    logic                  parity_s;
    logic                  bit_end_s;

    parity_bit_generator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_bit_generator (
        .data     (tx_data),
        .par_type (par_type),
        .parity   (parity_s)
    );

    // A bit period ends on the tick that would take tick_cnt past OVERSAMPLE-1.
    always_comb begin
        bit_end_s = sample_tick && (tick_cnt_r == TICK_LAST);
    end

    // Frame FSM with counters, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= TX_IDLE;
            tick_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            parity_r    <= 1'b0;
            tx_ready_r  <= 1'b1;
            tx_serial_r <= 1'b1;
            tx_done_r   <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            case (state_r)
                TX_IDLE: begin
                    tx_serial_r <= 1'b1;
                    // tx_ready_r is always high here, so tx_valid alone means accept.
                    if (tx_valid) begin
                        shift_r     <= tx_data;
                        parity_r    <= parity_s;
                        tick_cnt_r  <= '0;
                        bit_cnt_r   <= '0;
                        tx_ready_r  <= 1'b0;
                        tx_serial_r <= 1'b0;
                        state_r     <= TX_START;
                    end
                end

                TX_START: begin
                    if (bit_end_s) begin
                        tick_cnt_r  <= '0;
                        bit_cnt_r   <= '0;
                        tx_serial_r <= shift_r[0];
                        state_r     <= TX_DATA;
                    end else if (sample_tick) begin
                        tick_cnt_r <= tick_cnt_r + 1'b1;
                    end
                end

                TX_DATA: begin
                    if (bit_end_s) begin
                        tick_cnt_r <= '0;
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_serial_r <= parity_r;
                            state_r     <= TX_PARITY;
`else
                            tx_serial_r <= 1'b1;
                            state_r     <= TX_STOP;
`endif
                        end else begin
                            // Drive the next bit now so the line changes on this edge.
                            shift_r     <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                            tx_serial_r <= shift_r[1];
                            bit_cnt_r   <= bit_cnt_r + 1'b1;
                        end
                    end else if (sample_tick) begin
                        tick_cnt_r <= tick_cnt_r + 1'b1;
                    end
                end

                TX_PARITY: begin
                    if (bit_end_s) begin
                        tick_cnt_r  <= '0;
                        bit_cnt_r   <= '0;
                        tx_serial_r <= 1'b1;
                        state_r     <= TX_STOP;
                    end else if (sample_tick) begin
                        tick_cnt_r <= tick_cnt_r + 1'b1;
                    end
                end

                TX_STOP: begin
                    tx_serial_r <= 1'b1;
                    if (bit_end_s) begin
                        tick_cnt_r <= '0;
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r  <= '0;
                            tx_done_r  <= 1'b1;
                            tx_ready_r <= 1'b1;
                            state_r    <= TX_IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end else if (sample_tick) begin
                        tick_cnt_r <= tick_cnt_r + 1'b1;
                    end
                end

                default: begin
                    state_r     <= TX_IDLE;
                    tick_cnt_r  <= '0;
                    bit_cnt_r   <= '0;
                    tx_ready_r  <= 1'b1;
                    tx_serial_r <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready  = tx_ready_r;
    assign tx_serial = tx_serial_r;
    assign tx_done   = tx_done_r;

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// ----------------------------------------------------------------------------
// tb_uart_transmitter
// Directed bench for uart_transmitter. Frames are checked mid-bit against
// hand-built bit lists; tx_done is checked one tick before and on the last
// tick of the frame. Define UART_TX_PARITY_EN for both bench and RTL to
// exercise the parity build.
// ----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int DATA_WIDTH = 8;
    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = OVERSAMPLE / 2;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_WIDTH + PAR_BITS + 1;

    logic                  clk;
    logic                  reset;
    logic                  sample_tick;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  par_type;
    logic                  tx_ready;
    logic                  tx_serial;
    logic                  tx_done;

    int errors = 0;
    int checks = 0;
    int tick_div = 0;

    uart_transmitter #(
        .DATA_WIDTH (DATA_WIDTH),
        .OVERSAMPLE (OVERSAMPLE),
        .STOP_BITS  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .par_type    (par_type),
        .tx_ready    (tx_ready),
        .tx_serial   (tx_serial),
        .tx_done     (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sample_tick every third clock, changed on the falling edge.
    initial sample_tick = 1'b0;
    always @(negedge clk) begin
        if (tick_div == 2) begin
            sample_tick = 1'b1;
            tick_div    = 0;
        end else begin
            sample_tick = 1'b0;
            tick_div    = tick_div + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait until n sample ticks have been seen at clock edges; returns #1 after
    // the edge that carried the n-th tick. drop lowers tx_valid after the first edge.
    task automatic wait_ticks(input int n, input bit drop);
        int cnt;
        int clocks;
        logic timed_out;
        cnt       = 0;
        clocks    = 0;
        timed_out = 1'b0;
        while (cnt < n && !timed_out) begin
            @(posedge clk);
            if (sample_tick) cnt++;
            #1;
            if (drop) tx_valid = 1'b0;
            clocks++;
            if (clocks > n * 3 + 20) timed_out = 1'b1;
        end
        if (timed_out) check_val("tick_budget", 32'(timed_out), 32'd0);
    endtask

    // Check a frame whose accept edge has just passed (#1 after it).
    task automatic frame_body(input logic [7:0] data, input logic exp_par, input bit poke);
        logic exp_bits [FRAME_BITS];
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) exp_bits[1 + i] = data[i];
        if (PAR_BITS == 1) exp_bits[1 + DATA_WIDTH] = exp_par;
        exp_bits[FRAME_BITS - 1] = 1'b1;

        for (int i = 0; i < FRAME_BITS; i++) begin
            wait_ticks(HALF_BIT, 1'b0);
            check_val($sformatf("bit%0d_%02h", i, data), 32'(tx_serial), 32'(exp_bits[i]));
            if (i == 1) check_val("ready_busy", 32'(tx_ready), 32'd0);
            if (poke && i == 2) begin
                // Request and new inputs mid-frame; none of it may reach the line.
                tx_valid = 1'b1;
                tx_data  = ~data;
                par_type = ~par_type;
            end
            if (i == FRAME_BITS - 1) begin
                wait_ticks(HALF_BIT - 1, poke);
                check_val("done_early", 32'(tx_done), 32'd0);
                wait_ticks(1, 1'b0);
                check_val("done_pulse", 32'(tx_done), 32'd1);
                check_val("ready_end", 32'(tx_ready), 32'd1);
                check_val("serial_end", 32'(tx_serial), 32'd1);
            end else begin
                wait_ticks(OVERSAMPLE - HALF_BIT, poke && i == 2);
            end
        end
    endtask

    task automatic send(input logic [7:0] data, input logic par, input logic exp_par, input bit poke);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = data;
        par_type = par;
        check_val("ready_idle", 32'(tx_ready), 32'd1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_val("start_line", 32'(tx_serial), 32'd0);
        check_val("ready_drop", 32'(tx_ready), 32'd0);
        frame_body(data, exp_par, poke);
    endtask

    // Hand-computed vectors: data, par_type, expected parity bit.
    logic [7:0] vec_data [5] = '{8'hA5, 8'hA5, 8'h00, 8'hFF, 8'h3C};
    logic       vec_par  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       vec_exp  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int lows;
        int dones;
        logic [7:0] rnd;
        logic       rpar;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        par_type = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_serial", 32'(tx_serial), 32'd1);
        check_val("rst_ready", 32'(tx_ready), 32'd1);
        check_val("rst_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed frames; the 0xFF frame also carries a mid-frame request.
        for (int v = 0; v < 5; v++) begin
            send(vec_data[v], vec_par[v], vec_exp[v], (v == 3));
            repeat (4) @(posedge clk);
        end

        // Back-to-back with tx_valid held: 0x55 then 0xAA.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        par_type = 1'b0;
        @(posedge clk);
        #1;
        check_val("b2b_start1", 32'(tx_serial), 32'd0);
        tx_data = 8'hAA;
        frame_body(8'h55, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_val("b2b_start2", 32'(tx_serial), 32'd0);
        check_val("b2b_ready2", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        frame_body(8'hAA, 1'b0, 1'b0);

        // Reset in the middle of the data bits of a frame.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        par_type = 1'b0;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_ticks(OVERSAMPLE + HALF_BIT + 3 * OVERSAMPLE, 1'b0);
        check_val("pre_rst_busy", 32'(tx_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_serial", 32'(tx_serial), 32'd1);
        check_val("midrst_ready", 32'(tx_ready), 32'd1);
        check_val("midrst_done", 32'(tx_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        lows  = 0;
        dones = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (!tx_serial) lows++;
            if (tx_done) dones++;
        end
        check_val("post_rst_lows", 32'(lows), 32'd0);
        check_val("post_rst_dones", 32'(dones), 32'd0);

        // Recovery and a few random bytes.
        send(8'h3C, 1'b1, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            rnd  = 8'($urandom_range(0, 255));
            rpar = 1'($urandom_range(0, 1));
            repeat (2) @(posedge clk);
            send(rnd, rpar, (^rnd) ^ rpar, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_uart_transmitter
